ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver; pops raw scan-code bytes (Set 2) over a valid/ready handshake.
- Parses make, break (F0) and extended (E0) prefixes; tracks the currently held key; maps make codes to ASCII.
- Produces a one-cycle key event pulse plus registered key state for the seven-segment, LED and future text-mode VGA paths.

Parameters:
- CNT_W, 8, width of the fresh-press counter.
- ASCII_NONE, 8'h00, ASCII value driven for unmapped or extended codes.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  receiver has a byte available
- in_data  in  8  scan-code byte from the receiver
- in_ready  out  1  decoder accepts byte; the receiver pops on in_valid & in_ready
- event_valid  out  1  one-cycle pulse when a complete make or break sequence finishes
- key_down  out  1  a key is currently held
- key_ext  out  1  the last completed sequence carried E0
- key_code  out  8  last completed scan code, prefixes stripped
- key_ascii  out  8  ASCII of the held key; ASCII_NONE when released or unmapped
- press_count  out  CNT_W  count of fresh presses, excluding typematic repeats

Behaviour:
- Reset: all outputs 0 except in_ready = 0. The FSM returns to S_IDLE and held_code = 0, held_ext = 0. Reset is asynchronous and wins over any other event, including mid-sequence.
- in_ready = 1 in every state once out of reset. A byte is accepted on clock edges where in_valid & in_ready.
- FSM states: S_IDLE, S_E0, S_F0, S_E0F0. Transitions on accepted bytes:
  - S_IDLE: E0 -> S_E0; F0 -> S_F0; any other byte -> make(code, ext=0), stay in S_IDLE.
  - S_E0: F0 -> S_E0F0; E0 -> stay in S_E0; other -> make(code, ext=1) -> S_IDLE.
  - S_F0: F0 or E0 -> protocol error, go to S_IDLE with no event; other -> break(code, ext=0) -> S_IDLE.
  - S_E0F0: F0 or E0 -> error, go to S_IDLE; other -> break(code, ext=1) -> S_IDLE.
- make(c, e), registered on the edge after acceptance:
  - Outputs: key_code = c, key_ext = e, key_down = 1, event_valid = 1.
  - Fresh-press check: if !(key_down_prev & held_code == c & held_ext == e), press_count increments, wrapping mod 2^CNT_W.
  - Then held_code = c, held_ext = e.
  - key_ascii = rom(c) when e = 0, else ASCII_NONE.
- break(c, e):
  - Always: key_code = c, key_ext = e, event_valid = 1.
  - If c/e matches the held key: key_down = 0, key_ascii = ASCII_NONE.
  - Otherwise: key_down and key_ascii are unchanged (stale break of a non-held key).
- Latency: event_valid pulses exactly 1 cycle after the final byte is accepted. At most one event per accepted byte.
- Only one held key is tracked. A new make while another key is held replaces it and counts as fresh.
- Prefix bytes alone never pulse event_valid.

Optional Feature:
- Macro: PS2_KEYDEC_SHIFT_EN.
- When defined:
  - Left shift (12) and right shift (59) make/break codes update a shift_held flag instead of held_code/key_down. They still pulse event_valid and update key_code.
  - Letters map to uppercase while shift is held; digit row maps to the shifted symbols.
  - shift_held resets to 0.
- When undefined: 12 and 59 are ordinary keys mapping to ASCII_NONE; output is lowercase only.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants SC_E0 = 8'hE0, SC_F0 = 8'hF0, SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59;
  - FSM state enum dec_state_t (2 bits);
  - ASCII_NONE default.
- One sub-module, ps2_ascii_rom: combinational lookup from (code, shift) to 8-bit ASCII. Letters, digits, space (29 -> 20), enter (5A -> 0D); everything else maps to ASCII_NONE.

Test Plan:
- Reset release, then byte 1C -> event_valid pulses 1 cycle later; key_code = 1C, key_down = 1, key_ascii = 61, press_count = 1.
- Bytes 1C, 1C, 1C (typematic repeat) -> three event_valid pulses; press_count stays 1. Then F0, 1C -> key_down = 0, key_ascii = 00, press_count = 1.
- Bytes E0, 75 -> key_ext = 1, key_code = 75, key_ascii = 00, key_down = 1. Then E0, F0, 75 -> key_down = 0, key_ext = 1.
- Hold 1C, then F0, 32 (stale break) -> event_valid pulses; key_down stays 1, key_ascii stays 61. Then 255 alternating fresh makes of 1C / 32 starting at press_count = 1 -> press_count wraps to 0.
- Byte E0, then reset asserted mid-cycle, then byte 1C after release -> key_ext = 0, press_count = 1 (FSM restarted in S_IDLE, all outputs 0 during reset). Sequence F0, F0 -> no event, FSM back in S_IDLE.
- With PS2_KEYDEC_SHIFT_EN: 12, 1C -> key_ascii = 41; F0, 12, then 1C -> 61. Without the macro: 12 -> key_down = 1, key_ascii = 00.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, decoder FSM state type and default ASCII value
package ps2_pkg;
  localparam logic [7:0] SC_E0      = 8'hE0;
  localparam logic [7:0] SC_F0      = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] ASCII_NONE = 8'h00;
  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} dec_state_t;
endpackage

// File: rtl/ps2_ascii_rom.sv
// ps2_ascii_rom: Set 2 make code plus shift state to ASCII lookup
module ps2_ascii_rom #(
  parameter logic [7:0] ASCII_NONE = ps2_pkg::ASCII_NONE
) (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);
  logic [7:0] low, sym;
  always_comb begin
    low = ASCII_NONE;
    sym = ASCII_NONE;
    case (code)
      8'h1C: low = "a";
      8'h32: low = "b";
      8'h21: low = "c";
      8'h23: low = "d";
      8'h24: low = "e";
      8'h2B: low = "f";
      8'h34: low = "g";
      8'h33: low = "h";
      8'h43: low = "i";
      8'h3B: low = "j";
      8'h42: low = "k";
      8'h4B: low = "l";
      8'h3A: low = "m";
      8'h31: low = "n";
      8'h44: low = "o";
      8'h4D: low = "p";
      8'h15: low = "q";
      8'h2D: low = "r";
      8'h1B: low = "s";
      8'h2C: low = "t";
      8'h3C: low = "u";
      8'h2A: low = "v";
      8'h1D: low = "w";
      8'h22: low = "x";
      8'h35: low = "y";
      8'h1A: low = "z";
      8'h16: {low, sym} = {"1", "!"};
      8'h1E: {low, sym} = {"2", "@"};
      8'h26: {low, sym} = {"3", "#"};
      8'h25: {low, sym} = {"4", "$"};
      8'h2E: {low, sym} = {"5", "%"};
      8'h36: {low, sym} = {"6", "^"};
      8'h3D: {low, sym} = {"7", "&"};
      8'h3E: {low, sym} = {"8", "*"};
      8'h46: {low, sym} = {"9", "("};
      8'h45: {low, sym} = {"0", ")"};
      8'h29: low = " ";
      8'h5A: low = 8'h0D;
      default: ;
    endcase
  end
  // space and enter have no shifted form, so they fall through to low
  assign ascii = !shift ? low :
                 (low >= "a" && low <= "z") ? low - 8'h20 :
                 (sym != ASCII_NONE) ? sym : low;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 Set 2 byte parser tracking the held key, its ASCII and fresh presses
// Optional shift tracking for 12/59 enabled with `define PS2_KEYDEC_SHIFT_EN
module ps2_key_decoder #(
  parameter int         CNT_W      = 8,
  parameter logic [7:0] ASCII_NONE = ps2_pkg::ASCII_NONE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             event_valid,
  output logic             key_down,
  output logic             key_ext,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic [CNT_W-1:0] press_count
);
  import ps2_pkg::*;
  dec_state_t state, state_n;
  logic       acc, is_pfx, do_make, do_break, ext, is_shift, rom_shift, held_ext;
  logic [7:0] held_code, rom_ascii;
  assign acc    = in_valid & in_ready;
  assign is_pfx = in_data == SC_E0 || in_data == SC_F0;
  always_comb begin
    state_n  = state;
    do_make  = 1'b0;
    do_break = 1'b0;
    ext      = state == S_E0 || state == S_E0F0;
    if (acc)
      case (state)
        S_IDLE: begin
          state_n = in_data == SC_E0 ? S_E0 : in_data == SC_F0 ? S_F0 : S_IDLE;
          do_make = !is_pfx;
        end
        S_E0: begin
          state_n = in_data == SC_F0 ? S_E0F0 : in_data == SC_E0 ? S_E0 : S_IDLE;
          do_make = !is_pfx;
        end
        default: begin
          state_n  = S_IDLE;
          do_break = !is_pfx;
        end
      endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
`ifdef PS2_KEYDEC_SHIFT_EN
  logic shift_held;
  assign is_shift  = !ext && (in_data == SC_LSHIFT || in_data == SC_RSHIFT);
  assign rom_shift = shift_held;
  always_ff @(posedge clock or posedge reset)
    if (reset) shift_held <= 1'b0;
    else if (is_shift && (do_make || do_break)) shift_held <= do_make;
`else
  assign is_shift  = 1'b0;
  assign rom_shift = 1'b0;
`endif
  ps2_ascii_rom #(.ASCII_NONE(ASCII_NONE)) u_rom (
    .code  (in_data),
    .shift (rom_shift),
    .ascii (rom_ascii)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      in_ready    <= 1'b0;
      event_valid <= 1'b0;
      key_down    <= 1'b0;
      key_ext     <= 1'b0;
      key_code    <= '0;
      key_ascii   <= '0;
      press_count <= '0;
      held_code   <= '0;
      held_ext    <= 1'b0;
    end else begin
      in_ready    <= 1'b1;
      event_valid <= do_make | do_break;
      if (do_make || do_break) begin
        key_code <= in_data;
        key_ext  <= ext;
      end
      if (do_make && !is_shift) begin
        // a repeat of the already-held key is typematic, not a fresh press
        if (!(key_down && held_code == in_data && held_ext == ext)) press_count <= press_count + 1'b1;
        key_down  <= 1'b1;
        held_code <= in_data;
        held_ext  <= ext;
        key_ascii <= ext ? ASCII_NONE : rom_ascii;
      end
      if (do_break && !is_shift && held_code == in_data && held_ext == ext) begin
        key_down  <= 1'b0;
        key_ascii <= ASCII_NONE;
      end
    end
endmodule
